// File: rtl/regfile_bist_pkg.sv
// ============================================================================
// Module      : regfile_bist_pkg
// Description : Shared types and defaults for the register-file BIST
//               controller: state encoding, pattern mode codes and default
//               geometry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_bist_pkg;

    localparam int DEFAULT_AW    = 3;
    localparam int DEFAULT_DW    = 32;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_XOR   = 2'd1,
        MODE_ALT   = 2'd2,
        MODE_ROT   = 2'd3
    } mode_t;

endpackage

`default_nettype wire

// File: rtl/regfile_bist_if.sv
// ============================================================================
// Module      : regfile_bist_if
// Description : Register-file write/read port bundle. The BIST controller is
//               the master; the register file is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_bist_if
    import regfile_bist_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) ();

    logic          rf_we;
    logic [AW-1:0] rf_wAddr;
    logic [DW-1:0] rf_wData;
    logic          rf_re;
    logic [AW-1:0] rf_rAddr;
    logic [DW-1:0] rf_rData;

    modport master (
        output rf_we,
        output rf_wAddr,
        output rf_wData,
        output rf_re,
        output rf_rAddr,
        input  rf_rData
    );

    modport slave (
        input  rf_we,
        input  rf_wAddr,
        input  rf_wData,
        input  rf_re,
        input  rf_rAddr,
        output rf_rData
    );

endinterface

`default_nettype wire

// File: rtl/regfile_bist_pat.sv
// ============================================================================
// Module      : regfile_bist_pat
// Description : Combinational test-pattern generator pat(mode, seed, addr).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_bist_pat
    import regfile_bist_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  mode_t         mode_i,
    input  logic [DW-1:0] seed_i,
    input  logic [AW-1:0] addr_i,
    output logic [DW-1:0] pat_o
);

    logic [DW-1:0]   w_addr_ext;
    logic [2*DW-1:0] w_rot_dbl;

    assign w_addr_ext = DW'(addr_i);
    // Shifting a doubled copy left leaves the rotated word in the upper half.
    assign w_rot_dbl  = {seed_i, seed_i} << addr_i;

    // Select the pattern for this address according to the latched mode.
    always_comb begin
        pat_o = seed_i;
        case (mode_i)
            MODE_CONST: pat_o = seed_i;
            MODE_XOR:   pat_o = seed_i ^ w_addr_ext;
            MODE_ALT:   pat_o = addr_i[0] ? ~seed_i : seed_i;
            MODE_ROT:   pat_o = w_rot_dbl[2*DW-1:DW];
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/regfile_bist.sv
// ============================================================================
// Module      : regfile_bist
// Description : Register-file BIST controller. Writes a generated pattern to
//               every entry, reads it back through a one-stage compare
//               pipeline and reports pass/fail plus first-failure details.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_bist
    import regfile_bist_pkg::*;
#(
    parameter int AW    = DEFAULT_AW,
    parameter int DW    = DEFAULT_DW,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] seed,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_count,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    regfile_bist_if.master rf
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   ERR_MAX   = '1;

    state_t        state_q;
    mode_t         mode_q;
    logic [DW-1:0] seed_q;
    logic [AW-1:0] addr_q;
    logic          cmp_valid_q;
    logic [AW-1:0] cmp_addr_q;
    logic [AW:0]   err_count_q;
    logic [AW-1:0] fail_addr_q;
    logic [DW-1:0] fail_data_q;
    logic          pass_q;
    logic          busy_q;
    logic          done_q;
    logic          we_q;
    logic          re_q;

    logic [AW:0]   err_count_d;
    logic [AW-1:0] fail_addr_d;
    logic [DW-1:0] fail_data_d;
    logic [DW-1:0] w_wr_pat;
    logic [DW-1:0] w_exp_pat;

    regfile_bist_pat #(.AW(AW), .DW(DW)) u_pat_wr (
        .mode_i (mode_q),
        .seed_i (seed_q),
        .addr_i (addr_q),
        .pat_o  (w_wr_pat)
    );

    regfile_bist_pat #(.AW(AW), .DW(DW)) u_pat_exp (
        .mode_i (mode_q),
        .seed_i (seed_q),
        .addr_i (cmp_addr_q),
        .pat_o  (w_exp_pat)
    );

    // Compare stage: count mismatches (saturating) and capture the first one.
    always_comb begin
        err_count_d = err_count_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (cmp_valid_q && (rf.rf_rData != w_exp_pat)) begin
            if (err_count_q == '0) begin
                fail_addr_d = cmp_addr_q;
                fail_data_d = rf.rf_rData;
            end
            if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    // Sequencer: state, address counter, compare pipeline and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_CONST;
            seed_q      <= '0;
            addr_q      <= '0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            err_count_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            cmp_valid_q <= 1'b0;
            err_count_q <= err_count_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q      <= mode_t'(mode);
                        seed_q      <= seed;
                        err_count_q <= '0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                        pass_q      <= 1'b0;
                        addr_q      <= '0;
                        busy_q      <= 1'b1;
                        we_q        <= 1'b1;
                        state_q     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (addr_q == LAST_ADDR) begin
                        addr_q  <= '0;
                        we_q    <= 1'b0;
                        re_q    <= 1'b1;
                        state_q <= ST_READ;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                ST_READ: begin
                    cmp_valid_q <= 1'b1;
                    cmp_addr_q  <= addr_q;
                    if (addr_q == LAST_ADDR) begin
                        addr_q  <= '0;
                        re_q    <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The final compare retires now, so use its outcome.
                    pass_q  <= (err_count_d == '0);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

    // Bus outputs are forced to zero whenever their port is inactive.
    assign rf.rf_we    = we_q;
    assign rf.rf_wAddr = we_q ? addr_q : '0;
    assign rf.rf_wData = we_q ? w_wr_pat : '0;
    assign rf.rf_re    = re_q;
    assign rf.rf_rAddr = re_q ? addr_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_regfile_bist.sv
// ============================================================================
// Module      : tb_regfile_bist
// Description : Self-checking bench for regfile_bist with a faultable
//               behavioural 8x32 register file and a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_bist;
    import regfile_bist_pkg::*;

    localparam int AW      = 3;
    localparam int DW      = 32;
    localparam int DEPTH   = 8;
    localparam int RUN_LEN = 2 * DEPTH + 2;
    localparam int PER_LEN = RUN_LEN + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] seed = '0;
    logic          busy, done, pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_bist_if #(.AW(AW), .DW(DW)) rf ();

    regfile_bist #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mode      (mode),
        .seed      (seed),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
        .rf        (rf)
    );

    // Behavioural register file with per-entry read faults.
    logic [DW-1:0] mem    [DEPTH];
    logic [DW-1:0] stuck0 [DEPTH];
    bit            zero_en[DEPTH];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] wseen  [DEPTH];

    function automatic logic [DW-1:0] faulted(logic [DW-1:0] d, int a);
        return zero_en[a] ? '0 : (d & ~stuck0[a]);
    endfunction

    always @(posedge clk) begin
        if (rf.rf_we) mem[rf.rf_wAddr] <= rf.rf_wData;
        if (rf.rf_re) rdata_q <= faulted(mem[rf.rf_rAddr], int'(rf.rf_rAddr));
    end
    assign rf.rf_rData = rdata_q;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_pat(int m, logic [DW-1:0] s, int a);
        case (m)
            0:       return s;
            1:       return s ^ DW'(a);
            2:       return (a % 2 == 0) ? s : ~s;
            default: return (a == 0) ? s : ((s << a) | (s >> (DW - a)));
        endcase
    endfunction

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            stuck0[i]  = '0;
            zero_en[i] = 1'b0;
        end
    endtask

    // Check all observable outputs at position ph of a run (19 = idle).
    task automatic check_phase(int ph, int m, logic [DW-1:0] s, string tg);
        bit            e_we, e_re;
        int            e_err, e_fa;
        logic [DW-1:0] e_fd, rd;
        e_we = (ph >= 1) && (ph <= DEPTH);
        e_re = (ph > DEPTH) && (ph <= 2 * DEPTH);
        check($sformatf("%s.c%0d.we", tg, ph), rf.rf_we, e_we);
        check($sformatf("%s.c%0d.re", tg, ph), rf.rf_re, e_re);
        check($sformatf("%s.c%0d.waddr", tg, ph), rf.rf_wAddr, e_we ? ph - 1 : 0);
        check($sformatf("%s.c%0d.wdata", tg, ph), rf.rf_wData,
              e_we ? ref_pat(m, s, ph - 1) : '0);
        check($sformatf("%s.c%0d.raddr", tg, ph), rf.rf_rAddr, e_re ? ph - DEPTH - 1 : 0);
        check($sformatf("%s.c%0d.busy", tg, ph), busy, ph <= 2 * DEPTH + 1);
        check($sformatf("%s.c%0d.done", tg, ph), done, ph == RUN_LEN);
        if (e_we) wseen[ph - 1] = rf.rf_wData;
        if (ph == RUN_LEN) begin
            e_err = 0; e_fa = 0; e_fd = '0;
            for (int a = 0; a < DEPTH; a++) begin
                rd = faulted(ref_pat(m, s, a), a);
                if (rd != ref_pat(m, s, a)) begin
                    if (e_err == 0) begin e_fa = a; e_fd = rd; end
                    e_err++;
                end
            end
            check({tg, ".pass"}, pass, e_err == 0);
            check({tg, ".err_count"}, err_count, e_err);
            check({tg, ".fail_addr"}, fail_addr, e_fa);
            check({tg, ".fail_data"}, fail_data, e_fd);
        end
    endtask

    // Issue start and check ncyc cycles; start stays high if hold is set.
    task automatic run(int m, logic [DW-1:0] s, int ncyc, bit hold, string tg);
        @(negedge clk);
        mode  = 2'(m);
        seed  = s;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            check_phase(((k - 1) % PER_LEN) + 1, m, s, tg);
        end
        start = 1'b0;
    endtask

    task automatic check_all_zero(string tg);
        check({tg, ".we"}, rf.rf_we, 0);
        check({tg, ".re"}, rf.rf_re, 0);
        check({tg, ".wdata"}, rf.rf_wData, 0);
        check({tg, ".waddr"}, rf.rf_wAddr, 0);
        check({tg, ".busy"}, busy, 0);
        check({tg, ".done"}, done, 0);
        check({tg, ".pass"}, pass, 0);
        check({tg, ".err_count"}, err_count, 0);
        check({tg, ".fail_addr"}, fail_addr, 0);
        check({tg, ".fail_data"}, fail_data, 0);
    endtask

    initial begin
        clear_faults();
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) reset_n = 1'b1;

        run(0, 32'h0000_0001, PER_LEN, 1'b0, "m0");
        check("m0.final_pass", pass, 1);

        run(3, 32'h0000_0001, PER_LEN, 1'b0, "m3");
        check("m3.wdata5", wseen[5], 32'h0000_0020);
        check("m3.final_pass", pass, 1);

        clear_faults();
        stuck0[5] = 32'h0000_0001;
        run(1, 32'h0000_00F0, PER_LEN, 1'b0, "m1");
        check("m1.err_count", err_count, 1);
        check("m1.fail_addr", fail_addr, 5);
        check("m1.fail_data", fail_data, 32'h0000_00F4);
        check("m1.pass", pass, 0);

        clear_faults();
        zero_en[3] = 1'b1;
        zero_en[6] = 1'b1;
        run(2, 32'hA5A5_A5A5, PER_LEN, 1'b0, "m2");
        check("m2.err_count", err_count, 2);
        check("m2.fail_addr", fail_addr, 3);
        check("m2.fail_data", fail_data, 0);

        // Reset in the middle of the write phase, then rerun.
        clear_faults();
        run(0, 32'hFFFF_FFFF, 4, 1'b0, "pre_rst");
        #2 reset_n = 1'b0;
        #1 check_all_zero("mid_rst");
        @(negedge clk) reset_n = 1'b1;
        run(0, 32'hFFFF_FFFF, PER_LEN, 1'b0, "post_rst");
        check("post_rst.final_pass", pass, 1);

        // Start held high: back-to-back runs with one idle cycle between.
        run(1, 32'h1234_5678, 2 * PER_LEN, 1'b1, "held");

        // Randomized runs with random single-bit stuck faults and dead entries.
        for (int r = 0; r < 8; r++) begin
            clear_faults();
            if ($urandom_range(0, 1) == 1)
                stuck0[$urandom_range(0, DEPTH - 1)] = 32'h1 << $urandom_range(0, DW - 1);
            if ($urandom_range(0, 2) == 0)
                zero_en[$urandom_range(0, DEPTH - 1)] = 1'b1;
            run(int'($urandom_range(0, 3)), $urandom, PER_LEN, 1'b0,
                $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
